// File: rtl/alu_multiword_seq_pkg.sv
// Shared types for the multi-precision ALU sequencer: slice opcodes, FSM states
// and the slice-index width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND  = 2'b00,
    ALU_OR   = 2'b01,
    ALU_ADD  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Slice counter width; a single-slice build still needs a 1-bit counter.
  function automatic int idx_width(input int nslices);
    return (nslices > 1) ? $clog2(nslices) : 1;
  endfunction

endpackage

// File: rtl/alu_multiword_seq_if.sv
// Command/result handshake bundle of alu_multiword_seq.
// res_zero exists only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_multiword_seq_if #(
  parameter int WIDTH   = 8,
  parameter int NSLICES = 4
);
  import alu_pkg::*;

  localparam int FULL_W = WIDTH * NSLICES;

  logic              cmd_valid;
  logic              cmd_ready;
  alu_op_e           cmd_op;
  logic              cmd_cin;
  logic [FULL_W-1:0] cmd_a;
  logic [FULL_W-1:0] cmd_b;

  logic              res_valid;
  logic              res_ready;
  logic [FULL_W-1:0] res_data;
  logic              res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic              res_zero;
`endif

`ifdef ALU_SEQ_ZERO_FLAG_EN
  modport master (
    output cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout, res_zero
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_cout, res_zero
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_cout
  );
`endif

endinterface

// File: rtl/alu_multiword_seq.sv
// Multi-precision sequencer for an external combinational WIDTH-bit ALU slice:
// one slice per cycle, LSB first, ADD carry chained. Optional ALU_SEQ_ZERO_FLAG_EN adds res_zero.
module alu_multiword_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NSLICES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_multiword_seq_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int                FULL_W   = WIDTH * NSLICES;
  localparam int                IDX_W    = idx_width(NSLICES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSLICES - 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  alu_op_e           op_q;
  logic              cin_q;
  logic [FULL_W-1:0] a_q;
  logic [FULL_W-1:0] b_q;
  logic              carry_q;
  logic [FULL_W-1:0] res_data_q;
  logic [FULL_W-1:0] res_data_next;
  logic              res_cout_q;
  logic              accept;
  logic              last_slice;
  int                sel;

  assign sel        = int'(idx_q) * WIDTH;
  assign last_slice = (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would make the result depend on process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_cin       = 1'b0;
    alu_op        = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so ready stays low for the whole reset window.
        bus.cmd_ready = rst_n;
        if (bus.cmd_valid && rst_n) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        alu_a  = a_q[sel +: WIDTH];
        alu_b  = b_q[sel +: WIDTH];
        alu_op = op_q;
        if (op_q == ALU_ADD) alu_cin = (idx_q == '0) ? cin_q : carry_q;
        if (last_slice) state_d = DONE;
      end

      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Current result with the slice under processing replaced by the ALU output.
  always_comb begin
    res_data_next             = res_data_q;
    res_data_next[sel +: WIDTH] = alu_result;
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic res_zero_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      op_q       <= ALU_AND;
      cin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      res_zero_q <= 1'b0;
`endif
    end else if (accept) begin
      // Result is cleared on accept so no slice of the previous command survives.
      idx_q      <= '0;
      op_q       <= bus.cmd_op;
      cin_q      <= bus.cmd_cin;
      a_q        <= bus.cmd_a;
      b_q        <= bus.cmd_b;
      carry_q    <= 1'b0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      res_zero_q <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      res_data_q <= res_data_next;
      carry_q    <= (op_q == ALU_ADD) ? alu_cout : 1'b0;
      if (last_slice) begin
        res_cout_q <= (op_q == ALU_ADD) ? alu_cout : 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        res_zero_q <= (res_data_next == '0);
`endif
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.res_data = res_data_q;
  assign bus.res_cout = res_cout_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign bus.res_zero = res_zero_q;
`endif

endmodule
